// File: rtl/func_pkg.sv
// Shared types for the functionality arbiter: resource mask width and channel states.
package func_pkg;

    localparam int N_FUNC = 3;

    typedef logic [N_FUNC-1:0] func_mask_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } ch_state_e;

endpackage

// File: rtl/func_channel.sv
// One arbiter channel: IDLE/ACTIVE FSM, frozen grant register, hold counter and timeout pulse.
module func_channel
    import func_pkg::*;
#(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       take,
    input  func_mask_t mask,
    input  logic       rel,
    output func_mask_t grant,
    output logic       busy,
    output logic       timeout
);

    localparam logic             TMO_EN   = 1'(HOLD_MAX > 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);

    ch_state_e        state_q, state_d;
    func_mask_t       grant_q, grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    // Next-state: a release wins over a timeout landing in the same cycle
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (take) begin
                    state_d = ACTIVE;
                    grant_d = mask;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    grant_d = {N_FUNC{1'b0}};
                end
            end
            ACTIVE: begin
                if (rel) begin
                    state_d = IDLE;
                    grant_d = {N_FUNC{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                end else if (TMO_EN && (cnt_q == CNT_LAST)) begin
                    state_d   = IDLE;
                    grant_d   = {N_FUNC{1'b0}};
                    cnt_d     = {CNT_W{1'b0}};
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = {N_FUNC{1'b0}};
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Channel state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= {N_FUNC{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant   = grant_q;
    assign busy    = (state_q == ACTIVE);
    assign timeout = timeout_q;

endmodule

// File: rtl/func_arbiter_ctrl.sv
// Two-requester functionality arbiter: resolves overlapping requests by fixed or
// round-robin priority and hands each channel its arbitrated mask.
module func_arbiter_ctrl
    import func_pkg::*;
#(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  func_mask_t F1,
    input  func_mask_t F2,
    input  logic       req1,
    input  logic       req2,
    input  logic       rel1,
    input  logic       rel2,
    input  logic       P_SIGNAL,
    input  logic       rr_en,
    output func_mask_t f1,
    output func_mask_t f2,
    output logic       busy1,
    output logic       busy2,
    output logic       conflict,
    output logic       timeout1,
    output logic       timeout2
);

    func_mask_t cand1_s, cand2_s, overlap_s, mask1_s, mask2_s;
    logic       conflict_s, win2_s, take1_s, take2_s;
    logic       rr_ptr_q, rr_ptr_d;
    logic       conflict_q, conflict_d;

    // Arbitration uses the registered grants, so bits freed this edge are only
    // visible to the other channel from the next edge on.
    always_comb begin
        cand1_s    = (req1 && !busy1) ? (F1 & ~f2) : {N_FUNC{1'b0}};
        cand2_s    = (req2 && !busy2) ? (F2 & ~f1) : {N_FUNC{1'b0}};
        overlap_s  = cand1_s & cand2_s;
        conflict_s = |overlap_s;
        win2_s     = rr_en ? rr_ptr_q : P_SIGNAL;
        if (win2_s) begin
            mask1_s = cand1_s & ~overlap_s;
            mask2_s = cand2_s;
        end else begin
            mask1_s = cand1_s;
            mask2_s = cand2_s & ~overlap_s;
        end
        take1_s    = |mask1_s;
        take2_s    = |mask2_s;
        conflict_d = conflict_s;
        if (conflict_s) begin
            rr_ptr_d = ~win2_s;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Round-robin pointer and conflict pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            conflict_q <= conflict_d;
        end
    end

    assign conflict = conflict_q;

    func_channel #(.HOLD_MAX(HOLD_MAX), .CNT_W(CNT_W)) u_ch1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .take    (take1_s),
        .mask    (mask1_s),
        .rel     (rel1),
        .grant   (f1),
        .busy    (busy1),
        .timeout (timeout1)
    );

    func_channel #(.HOLD_MAX(HOLD_MAX), .CNT_W(CNT_W)) u_ch2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .take    (take2_s),
        .mask    (mask2_s),
        .rel     (rel2),
        .grant   (f2),
        .busy    (busy2),
        .timeout (timeout2)
    );

endmodule

// File: tb/tb_func_arbiter_ctrl.sv
// Scoreboard bench for func_arbiter_ctrl: directed scenarios plus random traffic,
// checked against a per-resource ownership model.
module tb_func_arbiter_ctrl;

    localparam int HM = 16;

    typedef struct packed {
        logic       req1;
        logic       req2;
        logic       rel1;
        logic       rel2;
        logic       p;
        logic       rr;
        logic [2:0] a;
        logic [2:0] b;
    } stim_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] in_f1 = 3'b000, in_f2 = 3'b000;
    logic       req1 = 1'b0, req2 = 1'b0, rel1 = 1'b0, rel2 = 1'b0, psig = 1'b0, rr_en = 1'b0;
    logic [2:0] f1, f2;
    logic       busy1, busy2, conflict, timeout1, timeout2;

    int checks = 0;
    int errors = 0;

    logic [10:0] sb_q[$];

    // Reference model: who owns each resource, per-channel activity and age
    int owner[3];
    bit act[2];
    int age[2];
    bit rr_m;

    func_arbiter_ctrl #(.HOLD_MAX(HM), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .F1(in_f1), .F2(in_f2),
        .req1(req1), .req2(req2), .rel1(rel1), .rel2(rel2),
        .P_SIGNAL(psig), .rr_en(rr_en),
        .f1(f1), .f2(f2), .busy1(busy1), .busy2(busy2),
        .conflict(conflict), .timeout1(timeout1), .timeout2(timeout2)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int b = 0; b < 3; b++) owner[b] = 0;
        act[0] = 1'b0; act[1] = 1'b0;
        age[0] = 0;    age[1] = 0;
        rr_m   = 1'b0;
    endtask

    task automatic model_step(input stim_t s, output logic [10:0] e);
        int   snap[3];
        bit   want[2][3];
        bit   rq[2], rl[2], tout[2], any[2];
        logic [2:0] fm[2];
        bit   conf;
        int   win, los;
        logic [2:0] o1, o2;
        rq[0] = s.req1; rq[1] = s.req2;
        rl[0] = s.rel1; rl[1] = s.rel2;
        fm[0] = s.a;    fm[1] = s.b;
        snap = owner;
        conf = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tout[c] = 1'b0;
            for (int b = 0; b < 3; b++)
                want[c][b] = !act[c] && rq[c] && fm[c][b] && (snap[b] == 0);
        end
        for (int b = 0; b < 3; b++) if (want[0][b] && want[1][b]) conf = 1'b1;
        if (conf) begin
            win = s.rr ? int'(rr_m) : int'(s.p);
            los = 1 - win;
            for (int b = 0; b < 3; b++)
                if (want[0][b] && want[1][b]) want[los][b] = 1'b0;
            rr_m = (los == 1);
        end
        for (int c = 0; c < 2; c++) begin
            if (act[c]) begin
                if (rl[c] || (HM > 0 && age[c] == HM - 1)) begin
                    tout[c] = !rl[c];
                    act[c]  = 1'b0;
                    for (int b = 0; b < 3; b++) if (owner[b] == c + 1) owner[b] = 0;
                end else begin
                    age[c]++;
                end
            end
        end
        for (int c = 0; c < 2; c++) begin
            any[c] = 1'b0;
            for (int b = 0; b < 3; b++) if (want[c][b]) any[c] = 1'b1;
            if (any[c]) begin
                act[c] = 1'b1;
                age[c] = 0;
                for (int b = 0; b < 3; b++) if (want[c][b]) owner[b] = c + 1;
            end
        end
        for (int b = 0; b < 3; b++) begin
            o1[b] = (owner[b] == 1);
            o2[b] = (owner[b] == 2);
        end
        e = {o1, o2, act[0], act[1], conf, tout[0], tout[1]};
    endtask

    task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    // Drive one cycle of stimulus and queue the response expected after the next edge
    task automatic cyc(input logic r1, input logic r2, input logic l1, input logic l2,
                       input logic [2:0] a, input logic [2:0] b, input logic p, input logic rr);
        stim_t s;
        logic [10:0] e;
        @(negedge clk);
        s = {r1, r2, l1, l2, p, rr, a, b};
        req1 = r1; req2 = r2; rel1 = l1; rel2 = l2; in_f1 = a; in_f2 = b; psig = p; rr_en = rr;
        model_step(s, e);
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    endtask

    // Monitor: compare DUT outputs against the queued expectation after each edge
    always @(posedge clk) begin
        logic [10:0] exp_v;
        #1;
        if (sb_q.size() > 0) begin
            exp_v = sb_q.pop_front();
            check("outputs", {f1, f2, busy1, busy2, conflict, timeout1, timeout2}, exp_v);
            check("no_overlap", {8'd0, f1 & f2}, 11'd0);
        end
    end

    initial begin
        logic [10:0] zero_v;
        zero_v = 11'd0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("reset_state", {f1, f2, busy1, busy2, conflict, timeout1, timeout2}, zero_v);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-grant
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'b101, 3'b000, 1'b0, 1'b0);
        idle(2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset", {f1, f2, busy1, busy2, conflict, timeout1, timeout2}, zero_v);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Fixed-priority conflict, requester 2 wins
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'b011, 3'b110, 1'b1, 1'b0);
        idle(1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0);

        // Round-robin alternation
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'b111, 3'b111, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b111, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 3'b111, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b111, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'b111, 3'b111, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'b111, 3'b111, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1);

        // Busy resource, frozen mask, later re-request
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 3'b000, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b110, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 3'b110, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b110, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b100, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0);

        // Timeout, then release landing on the timeout cycle
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0);
        idle(HM + 2);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0);
        idle(HM - 1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
        idle(2);

        // Zero-grant retry while the other channel holds everything
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b111, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 3'b000, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);

        // Random traffic; releases are rare so timeouts also occur
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
                3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        @(posedge clk);
        #3;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d required=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
